// File: rtl/game_timer_ctrl.sv
// Frame-synchronous match timer: one tick per video frame from the scan origin,
// frames divided into seconds, and a command-driven countdown (IDLE/RUN/PAUSE/EXPIRED).
module game_timer_ctrl #(
    parameter int unsigned  FRAMES_PER_SEC = 60,
    parameter int unsigned  MAX_SECONDS    = 999,
    localparam int unsigned FDW            = $clog2(FRAMES_PER_SEC)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [9:0]     pixel_x,
    input  logic [9:0]     pixel_y,
    input  logic           cmd_valid,
    input  logic [1:0]     cmd_op,
    input  logic [9:0]     cmd_data,
    output logic           cmd_ready,
    output logic [9:0]     seconds_left,
    output logic [FDW-1:0] frame_div,
    output logic [1:0]     state,
    output logic           sec_tick,
    output logic           expired,
    output logic           cmd_err
);

    localparam int unsigned SW = 10;
    localparam logic [SW-1:0]  MAX_S     = SW'(MAX_SECONDS);
    localparam logic [FDW-1:0] FDIV_LAST = FDW'(FRAMES_PER_SEC - 1);

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_START = 2'b01;
    localparam logic [1:0] OP_PAUSE = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_EXP   = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [SW-1:0]  secs_d;
    logic [FDW-1:0] fdiv_d;
    logic           sec_tick_d, expired_d, cmd_err_d;
    logic           at_origin, at_origin_d;
    logic           frame_tick;
    logic           cmd_acc;

    // Rising edge of "scan at origin" gives exactly one tick per frame.
    assign at_origin  = (pixel_x == 10'd0) && (pixel_y == 10'd0);
    assign frame_tick = at_origin & ~at_origin_d;
    assign cmd_ready  = ~frame_tick;
    assign cmd_acc    = cmd_valid & cmd_ready;
    assign state      = state_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            at_origin_d  <= 1'b1;
            state_q      <= S_IDLE;
            seconds_left <= '0;
            frame_div    <= '0;
            sec_tick     <= 1'b0;
            expired      <= 1'b0;
            cmd_err      <= 1'b0;
        end else begin
            at_origin_d  <= at_origin;
            state_q      <= state_d;
            seconds_left <= secs_d;
            frame_div    <= fdiv_d;
            sec_tick     <= sec_tick_d;
            expired      <= expired_d;
            cmd_err      <= cmd_err_d;
        end
    end

    // Commands and ticks are mutually exclusive because cmd_ready drops on a tick.
    always_comb begin
        state_d    = state_q;
        secs_d     = seconds_left;
        fdiv_d     = frame_div;
        sec_tick_d = 1'b0;
        expired_d  = 1'b0;
        cmd_err_d  = 1'b0;

        if (cmd_acc) begin
            unique case (cmd_op)
                OP_LOAD: begin
                    if (state_q == S_RUN) begin
                        cmd_err_d = 1'b1;
                    end else begin
                        secs_d  = (cmd_data > MAX_S) ? MAX_S : cmd_data;
                        fdiv_d  = '0;
                        state_d = S_IDLE;
                    end
                end
                OP_START: begin
                    if (state_q == S_IDLE || state_q == S_PAUSE) begin
                        if (seconds_left != '0) begin
                            state_d = S_RUN;
                        end else begin
                            cmd_err_d = 1'b1;
                        end
                    end else if (state_q == S_EXP) begin
                        cmd_err_d = 1'b1;
                    end
                end
                OP_PAUSE: begin
                    if (state_q == S_RUN) begin
                        state_d = S_PAUSE;
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
                OP_CLEAR: begin
                    secs_d  = '0;
                    fdiv_d  = '0;
                    state_d = S_IDLE;
                end
                default: ;
            endcase
        end else if (frame_tick && state_q == S_RUN) begin
            if (frame_div != FDIV_LAST) begin
                fdiv_d = frame_div + FDW'(1);
            end else begin
                fdiv_d     = '0;
                sec_tick_d = 1'b1;
                if (seconds_left != '0) begin
                    secs_d = seconds_left - SW'(1);
                end
                if (seconds_left == SW'(1)) begin
                    state_d   = S_EXP;
                    expired_d = 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Directed table-driven bench for game_timer_ctrl with FRAMES_PER_SEC=4, MAX_SECONDS=999.
module tb_game_timer_ctrl;

    localparam logic [1:0] LD = 2'b00;
    localparam logic [1:0] ST = 2'b01;
    localparam logic [1:0] PS = 2'b10;
    localparam logic [1:0] CL = 2'b11;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] pixel_x, pixel_y;
    logic       cmd_valid;
    logic [1:0] cmd_op;
    logic [9:0] cmd_data;
    logic       cmd_ready;
    logic [9:0] seconds_left;
    logic [1:0] frame_div;
    logic [1:0] state;
    logic       sec_tick, expired, cmd_err;

    always #5 clk = ~clk;

    game_timer_ctrl #(.FRAMES_PER_SEC(4), .MAX_SECONDS(999)) dut (
        .clk(clk), .reset(reset),
        .pixel_x(pixel_x), .pixel_y(pixel_y),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .cmd_ready(cmd_ready), .seconds_left(seconds_left), .frame_div(frame_div),
        .state(state), .sec_tick(sec_tick), .expired(expired), .cmd_err(cmd_err)
    );

    typedef struct {
        logic       org;
        logic       cv;
        logic [1:0] op;
        logic [9:0] data;
        logic       rdy;
        logic [9:0] secs;
        logic [1:0] fdiv;
        logic [1:0] st;
        logic       tk;
        logic       ex;
        logic       er;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t mk(input logic org, input logic cv, input logic [1:0] op,
                                input logic [9:0] data, input logic rdy, input logic [9:0] secs,
                                input logic [1:0] fdiv, input logic [1:0] st,
                                input logic tk, input logic ex, input logic er);
        vec_t v;
        v.org = org; v.cv = cv; v.op = op; v.data = data; v.rdy = rdy;
        v.secs = secs; v.fdiv = fdiv; v.st = st; v.tk = tk; v.ex = ex; v.er = er;
        return v;
    endfunction

    task automatic add_cmd(input logic [1:0] op, input logic [9:0] data, input logic [9:0] secs,
                           input logic [1:0] fdiv, input logic [1:0] st, input logic er);
        tbl.push_back(mk(1'b0, 1'b1, op, data, 1'b1, secs, fdiv, st, 1'b0, 1'b0, er));
    endtask

    task automatic add_idle(input logic [9:0] secs, input logic [1:0] fdiv, input logic [1:0] st);
        tbl.push_back(mk(1'b0, 1'b0, LD, 10'd0, 1'b1, secs, fdiv, st, 1'b0, 1'b0, 1'b0));
    endtask

    // One frame origin cycle followed by one off-origin cycle.
    task automatic add_frame(input logic [9:0] secs, input logic [1:0] fdiv, input logic [1:0] st,
                             input logic tk, input logic ex);
        tbl.push_back(mk(1'b1, 1'b0, LD, 10'd0, 1'b0, secs, fdiv, st, tk, ex, 1'b0));
        add_idle(secs, fdiv, st);
    endtask

    task automatic apply(input vec_t v, input string tag);
        logic rdy_a;
        pixel_x   = v.org ? 10'd0 : 10'd100;
        pixel_y   = v.org ? 10'd0 : 10'd20;
        cmd_valid = v.cv;
        cmd_op    = v.op;
        cmd_data  = v.data;
        #1 rdy_a = cmd_ready;
        @(posedge clk);
        #1;
        n_vec++;
        if (rdy_a !== v.rdy || seconds_left !== v.secs || frame_div !== v.fdiv ||
            state !== v.st || sec_tick !== v.tk || expired !== v.ex || cmd_err !== v.er) begin
            n_bad++;
            $display("FAIL %s: got rdy=%b secs=%0d fdiv=%0d state=%0d tick=%b exp=%b err=%b, expected rdy=%b secs=%0d fdiv=%0d state=%0d tick=%b exp=%b err=%b",
                     tag, rdy_a, seconds_left, frame_div, state, sec_tick, expired, cmd_err,
                     v.rdy, v.secs, v.fdiv, v.st, v.tk, v.ex, v.er);
        end
    endtask

    initial begin
        reset     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = LD;
        cmd_data  = 10'd0;
        pixel_x   = 10'd100;
        pixel_y   = 10'd20;
        #12 reset = 1'b1;

        // Reset state, then basic countdown: LOAD 3, START, 12 frames.
        add_idle(0, 0, 0);
        add_cmd(LD, 10'd3, 3, 0, 0, 0);
        add_cmd(ST, 10'd0, 3, 0, 1, 0);
        add_frame(3, 1, 1, 0, 0);
        add_frame(3, 2, 1, 0, 0);
        add_frame(3, 3, 1, 0, 0);
        add_frame(2, 0, 1, 1, 0);
        add_frame(2, 1, 1, 0, 0);
        add_frame(2, 2, 1, 0, 0);
        add_frame(2, 3, 1, 0, 0);
        add_frame(1, 0, 1, 1, 0);
        add_frame(1, 1, 1, 0, 0);
        add_frame(1, 2, 1, 0, 0);
        add_frame(1, 3, 1, 0, 0);
        add_frame(0, 0, 3, 1, 1);
        add_cmd(ST, 10'd0, 0, 0, 3, 1);
        add_idle(0, 0, 3);

        // Pause and resume.
        add_cmd(LD, 10'd2, 2, 0, 0, 0);
        add_cmd(ST, 10'd0, 2, 0, 1, 0);
        add_frame(2, 1, 1, 0, 0);
        add_frame(2, 2, 1, 0, 0);
        add_cmd(PS, 10'd0, 2, 2, 2, 0);
        for (int i = 0; i < 5; i++) add_frame(2, 2, 2, 0, 0);
        add_cmd(ST, 10'd0, 2, 2, 1, 0);
        add_frame(2, 3, 1, 0, 0);
        add_frame(1, 0, 1, 1, 0);

        // Illegal commands, saturation and clear.
        add_frame(1, 1, 1, 0, 0);
        add_cmd(LD, 10'd5, 1, 1, 1, 1);
        add_cmd(CL, 10'd0, 0, 0, 0, 0);
        add_cmd(ST, 10'd0, 0, 0, 0, 1);
        add_cmd(PS, 10'd0, 0, 0, 0, 1);
        add_cmd(LD, 10'd1023, 999, 0, 0, 0);
        add_cmd(LD, 10'd1000, 999, 0, 0, 0);
        add_cmd(LD, 10'd999, 999, 0, 0, 0);
        add_cmd(ST, 10'd0, 999, 0, 1, 0);
        add_cmd(ST, 10'd0, 999, 0, 1, 0);
        add_cmd(PS, 10'd0, 999, 0, 2, 0);
        add_cmd(PS, 10'd0, 999, 0, 2, 1);
        add_cmd(LD, 10'd1, 1, 0, 0, 0);
        add_cmd(CL, 10'd0, 0, 0, 0, 0);
        add_idle(0, 0, 0);

        foreach (tbl[i]) apply(tbl[i], $sformatf("tbl[%0d]", i));

        // Origin held for 10 clocks produces a single tick.
        apply(mk(0, 1, LD, 10'd3, 1, 3, 0, 0, 0, 0, 0), "held_load");
        apply(mk(0, 1, ST, 10'd0, 1, 3, 0, 1, 0, 0, 0), "held_start");
        for (int i = 0; i < 10; i++)
            apply(mk(1, 0, LD, 10'd0, (i == 0) ? 1'b0 : 1'b1, 3, 1, 1, 0, 0, 0),
                  $sformatf("held_origin[%0d]", i));
        apply(mk(0, 0, LD, 10'd0, 1, 3, 1, 1, 0, 0, 0), "held_release");

        // START coinciding with a tick is stalled one cycle.
        apply(mk(0, 1, PS, 10'd0, 1, 3, 1, 2, 0, 0, 0), "coll_pause");
        apply(mk(1, 1, ST, 10'd0, 0, 3, 1, 2, 0, 0, 0), "coll_stall");
        apply(mk(1, 1, ST, 10'd0, 1, 3, 1, 1, 0, 0, 0), "coll_accept");
        apply(mk(0, 0, LD, 10'd0, 1, 3, 1, 1, 0, 0, 0), "coll_idle");
        apply(mk(1, 0, LD, 10'd0, 0, 3, 2, 1, 0, 0, 0), "coll_frame");
        apply(mk(0, 0, LD, 10'd0, 1, 3, 2, 1, 0, 0, 0), "coll_frame_idle");

        // Async reset mid-run with 7 seconds loaded.
        apply(mk(0, 1, PS, 10'd0, 1, 3, 2, 2, 0, 0, 0), "rst_pause");
        apply(mk(0, 1, LD, 10'd7, 1, 7, 0, 0, 0, 0, 0), "rst_load7");
        apply(mk(0, 1, ST, 10'd0, 1, 7, 0, 1, 0, 0, 0), "rst_start");
        apply(mk(1, 0, LD, 10'd0, 0, 7, 1, 1, 0, 0, 0), "rst_frame");
        apply(mk(0, 0, LD, 10'd0, 1, 7, 1, 1, 0, 0, 0), "rst_idle");
        cmd_valid = 1'b0;
        #2;
        pixel_x = 10'd0;
        pixel_y = 10'd0;
        reset   = 1'b0;
        #1;
        n_vec++;
        if (seconds_left !== 10'd0 || frame_div !== 2'd0 || state !== 2'd0 || sec_tick !== 1'b0 ||
            expired !== 1'b0 || cmd_err !== 1'b0 || cmd_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL async_reset: got rdy=%b secs=%0d fdiv=%0d state=%0d tick=%b exp=%b err=%b, expected rdy=1 secs=0 fdiv=0 state=0 tick=0 exp=0 err=0",
                     cmd_ready, seconds_left, frame_div, state, sec_tick, expired, cmd_err);
        end
        #2 reset = 1'b1;
        apply(mk(1, 0, LD, 10'd0, 1, 0, 0, 0, 0, 0, 0), "post_rst_origin");
        apply(mk(1, 1, LD, 10'd2, 1, 2, 0, 0, 0, 0, 0), "post_rst_load");
        apply(mk(1, 1, ST, 10'd0, 1, 2, 0, 1, 0, 0, 0), "post_rst_start");
        apply(mk(0, 0, LD, 10'd0, 1, 2, 0, 1, 0, 0, 0), "post_rst_idle");
        apply(mk(1, 0, LD, 10'd0, 0, 2, 1, 1, 0, 0, 0), "post_rst_frame");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/game_timer_ctrl.md
# game_timer_ctrl

Frame-synchronous match-timer controller for the AR robot game. It derives one tick per video frame from the VGA scan coordinates, divides frames into seconds, and runs a countdown under command control from the game logic. The state machine is IDLE / RUN / PAUSE / EXPIRED. It sits beside the frame counter in the video pipeline, and its outputs feed the HUD overlay and the robot-command arbiter, which stops robots on expiry.

## Interface
- FRAMES_PER_SEC, default 60: frame ticks per second decrement. Legal range is 2..255.
- MAX_SECONDS, default 999: saturation limit for loaded seconds. Must be ≤ 1023.
- clk  in  1: single clock. All logic is on the rising edge.
- reset  in  1: asynchronous, active-low reset.
- pixel_x  in  10: current scan column.
- pixel_y  in  10: current scan row.
- cmd_valid  in  1: a command is presented.
- cmd_op  in  2: command code. 00 LOAD, 01 START, 10 PAUSE, 11 CLEAR.
- cmd_data  in  10: seconds value, used by LOAD only.
- cmd_ready  out  1: the controller can accept a command this cycle.
- seconds_left  out  10: remaining seconds.
- frame_div  out  clog2(FRAMES_PER_SEC): frames elapsed within the current second.
- state  out  2: current state. 0 IDLE, 1 RUN, 2 PAUSE, 3 EXPIRED.
- sec_tick  out  1: one-cycle pulse on each seconds decrement.
- expired  out  1: one-cycle pulse on the RUN→EXPIRED transition.
- cmd_err  out  1: one-cycle pulse when an accepted command is illegal in the current state.

## Operation
- **Origin detection.** `at_origin = (pixel_x==0 && pixel_y==0)` is registered into `at_origin_d`.
- **Frame tick.** `frame_tick = at_origin & ~at_origin_d`. There is exactly one tick per frame, even if the coordinates hold at origin for many clocks.
- **Command handshake.** `cmd_ready = ~frame_tick`, combinational. A command is accepted only when `cmd_valid && cmd_ready`.
  - The requester holds `cmd_valid`, `cmd_op` and `cmd_data` until accepted.
  - A tick and a command never take effect in the same cycle.
- **LOAD.** Legal in IDLE, PAUSE and EXPIRED.
  - Sets `seconds_left = min(cmd_data, MAX_SECONDS)` and `frame_div = 0`, and moves to IDLE.
  - In RUN: no state change, `cmd_err` pulses.
- **START.** Legal in IDLE and PAUSE when `seconds_left != 0`; moves to RUN.
  - When `seconds_left == 0`, or from EXPIRED: `cmd_err` pulses and the state is held.
  - In RUN: no-op, no error.
- **PAUSE.** RUN→PAUSE, with `frame_div` and `seconds_left` frozen.
  - From any other state: `cmd_err` pulses.
- **CLEAR.** From any state: `seconds_left = 0`, `frame_div = 0`, moves to IDLE. Never an error.
- **RUN behaviour on frame_tick:**
  - If `frame_div != FRAMES_PER_SEC-1`: `frame_div` increments.
  - Otherwise: `frame_div = 0`, `seconds_left` decrements, and `sec_tick` pulses.
  - If that decrement takes `seconds_left` from 1 to 0: `state = EXPIRED` and `expired` pulses in the same cycle as `sec_tick`.
- **Ticks outside RUN.** In IDLE, PAUSE and EXPIRED, frame ticks change nothing.
- **Arithmetic.** All counters are unsigned. `seconds_left` never wraps below 0. `frame_div` wraps only via the explicit compare.

## Timing
- **Reset values:**
  - `state` = IDLE; `seconds_left` = 0; `frame_div` = 0.
  - `sec_tick`, `expired` and `cmd_err` = 0.
  - `at_origin_d` = 1, so no tick is produced on the first cycle after reset even if the scan is at origin.
  - `cmd_ready` is 1 out of reset.
- **Latency.** Registered outputs change on the clock edge that accepts the command or tick, i.e. the outputs are visible one cycle after acceptance.
- **Pulse width.** `sec_tick`, `expired` and `cmd_err` are registered and last exactly one cycle.
- **Reset mid-operation.** Asserting reset in any state returns all registers to their reset values immediately, regardless of the clock. On deassertion, the timer is IDLE with 0 seconds.
- **Command coinciding with a tick.** The command is stalled one cycle (`cmd_ready = 0`) and is accepted on the next cycle if still valid.

## Test plan
Bench uses FRAMES_PER_SEC=4 and MAX_SECONDS=999.
- **Basic countdown.** LOAD 3, START, then 12 frame origins.
  - `sec_tick` pulses at frames 4, 8 and 12; `seconds_left` goes 3→2→1→0.
  - `expired` pulses at frame 12; `state` = 3.
- **Pause and resume.** LOAD 2, START, 2 frames, PAUSE, 5 frames, START, 2 frames.
  - `frame_div` stays 2 during the pause.
  - Then `seconds_left` = 1, `frame_div` = 0, `sec_tick` has pulsed once.
- **Illegal commands.**
  - START with `seconds_left` = 0 → `cmd_err` pulse, state stays 0.
  - LOAD 5 while in RUN → `cmd_err`, `seconds_left` unchanged.
  - PAUSE in IDLE → `cmd_err`.
- **Saturation and clear.**
  - LOAD 1023 → `seconds_left` = 999.
  - CLEAR from RUN → state 0, `seconds_left` 0, `frame_div` 0.
- **Tick collision and held origin.**
  - Hold `pixel_x=pixel_y=0` for 10 clocks → exactly one `frame_div` increment.
  - A START presented on the tick cycle sees `cmd_ready` = 0 and is accepted the next cycle.
- **Async reset mid-run.**
  - Pulse reset low between clock edges while in RUN with `seconds_left` = 7 → all outputs return to their reset values immediately.
  - Origin present at release → no tick on the first cycle.
